// File: rtl/regfile8_if.sv
// rtl/regfile8_if.sv - write/read bus bundle for the eight-entry register file
interface regfile8_if #(parameter int WIDTH = 32);
  logic [7:0]       WE;
  logic [WIDTH-1:0] WD;
  logic [2:0]       RA1;
  logic [2:0]       RA2;
  logic             RE;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;
  logic             RVALID;
  logic             WERR;
  logic [7:0]       WCNT;

  modport master (
    output WE, WD, RA1, RA2, RE,
    input  RD1, RD2, RVALID, WERR, WCNT
  );

  modport slave (
    input  WE, WD, RA1, RA2, RE,
    output RD1, RD2, RVALID, WERR, WCNT
  );
endinterface

// File: rtl/regfile8.sv
// rtl/regfile8.sv - eight-entry register file, one-hot write, two registered read ports
// Optional macro REGFILE8_BYPASS_EN forwards same-edge write data to the read ports.
module regfile8 #(
  parameter int WIDTH = 32
) (
  input logic       CLK,
  input logic       RSTn,
  regfile8_if.slave bus
);

  logic [WIDTH-1:0] regs [8];
  logic [WIDTH-1:0] rd1_q, rd2_q;
  logic             rvalid_q;
  logic             werr_q;
  logic [7:0]       wcnt_q;

  logic             we_any;
  logic             we_one_hot;
  logic             we_multi;
  logic [2:0]       wr_idx;
  logic [WIDTH-1:0] rd1_src, rd2_src;

  // A value with a single bit set becomes zero when ANDed with itself minus one.
  assign we_any     = (bus.WE != 8'd0);
  assign we_one_hot = we_any && ((bus.WE & (bus.WE - 8'd1)) == 8'd0);
  assign we_multi   = we_any && !we_one_hot;

  always_comb begin
    wr_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.WE[i]) wr_idx = 3'(i);
    end
  end

`ifdef REGFILE8_BYPASS_EN
  assign rd1_src = (we_one_hot && bus.WE[bus.RA1]) ? bus.WD : regs[bus.RA1];
  assign rd2_src = (we_one_hot && bus.WE[bus.RA2]) ? bus.WD : regs[bus.RA2];
`else
  assign rd1_src = regs[bus.RA1];
  assign rd2_src = regs[bus.RA2];
`endif

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      rvalid_q <= 1'b0;
      werr_q   <= 1'b0;
      wcnt_q   <= 8'd0;
    end else begin
      if (we_one_hot) begin
        regs[wr_idx] <= bus.WD;
        wcnt_q       <= wcnt_q + 8'd1;
      end
      if (we_multi) werr_q <= 1'b1;
      if (bus.RE) begin
        rd1_q    <= rd1_src;
        rd2_q    <= rd2_src;
        rvalid_q <= 1'b1;
      end else begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign bus.RD1    = rd1_q;
  assign bus.RD2    = rd2_q;
  assign bus.RVALID = rvalid_q;
  assign bus.WERR   = werr_q;
  assign bus.WCNT   = wcnt_q;

endmodule

// File: tb/tb_regfile8.sv
// tb/tb_regfile8.sv - directed and randomized checks of regfile8 against a behavioural model
module tb_regfile8;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RSTn;
  int   checks = 0;
  int   failures = 0;

  regfile8_if #(.WIDTH(W)) bus ();
  regfile8 #(.WIDTH(W)) dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));

  initial forever #5 CLK = ~CLK;

  logic [W-1:0] m_reg [8];
  logic [W-1:0] m_rd1, m_rd2;
  logic         m_rvalid, m_werr;
  int           m_wcnt;
`ifdef REGFILE8_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rstn, input logic [7:0] we, input logic [W-1:0] wd,
                            input logic [2:0] ra1, input logic [2:0] ra2, input logic re);
    int n;
    n = $countones(we);
    if (!rstn) begin
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_rd1 = '0; m_rd2 = '0; m_rvalid = 0; m_werr = 0; m_wcnt = 0;
    end else begin
      if (re) begin
        m_rd1 = (BYPASS && n == 1 && we[ra1]) ? wd : m_reg[ra1];
        m_rd2 = (BYPASS && n == 1 && we[ra2]) ? wd : m_reg[ra2];
        m_rvalid = 1;
      end else begin
        m_rvalid = 0;
      end
      if (n == 1) begin
        for (int i = 0; i < 8; i++) if (we[i]) m_reg[i] = wd;
        m_wcnt = (m_wcnt + 1) % 256;
      end else if (n > 1) begin
        m_werr = 1;
      end
    end
  endtask

  task automatic step(input logic rstn, input logic [7:0] we, input logic [W-1:0] wd,
                      input logic [2:0] ra1, input logic [2:0] ra2, input logic re);
    RSTn = rstn; bus.WE = we; bus.WD = wd; bus.RA1 = ra1; bus.RA2 = ra2; bus.RE = re;
    @(posedge CLK);
    model_edge(rstn, we, wd, ra1, ra2, re);
    #1;
    chk("rd1",    bus.RD1,           m_rd1);
    chk("rd2",    bus.RD2,           m_rd2);
    chk("rvalid", W'(bus.RVALID),    W'(m_rvalid));
    chk("werr",   W'(bus.WERR),      W'(m_werr));
    chk("wcnt",   W'(bus.WCNT),      W'(m_wcnt));
  endtask

  initial begin
    logic [7:0] we;
    logic [2:0] idx, a1, a2;
    int r;

    step(0, 8'h00, '0, 3'd0, 3'd0, 0);
    step(0, 8'hFF, 32'hFFFF_FFFF, 3'd1, 3'd2, 1);
    chk("reset_rvalid", W'(bus.RVALID), '0);
    chk("reset_wcnt",   W'(bus.WCNT),   '0);

    step(1, 8'h00, '0, 3'd3, 3'd5, 1);
    chk("first_read_rd1", bus.RD1, '0);
    chk("first_read_rvalid", W'(bus.RVALID), W'(1));

    step(1, 8'h04, 32'hDEADBEEF, 3'd0, 3'd0, 0);
    step(1, 8'h00, '0, 3'd2, 3'd6, 1);
    chk("r2_value", bus.RD1, 32'hDEADBEEF);
    chk("wcnt_one", W'(bus.WCNT), W'(1));
    for (int i = 0; i < 8; i++) step(1, 8'h00, '0, 3'(i), 3'(i), 1);

    step(1, 8'h0C, 32'h12345678, 3'd0, 3'd0, 0);
    chk("werr_set", W'(bus.WERR), W'(1));
    step(1, 8'h00, '0, 3'd2, 3'd3, 1);
    chk("r2_kept", bus.RD1, 32'hDEADBEEF);
    chk("r3_kept", bus.RD2, '0);
    step(1, 8'h01, 32'h0000_00A5, 3'd0, 3'd0, 1);
    chk("werr_sticky", W'(bus.WERR), W'(1));

    step(1, 8'h10, 32'h11111111, 3'd0, 3'd0, 0);
    step(1, 8'h10, 32'h22222222, 3'd4, 3'd4, 1);
    chk("same_edge_rd1", bus.RD1, BYPASS ? 32'h22222222 : 32'h11111111);
    step(1, 8'h00, '0, 3'd4, 3'd1, 1);
    chk("after_write_rd1", bus.RD1, 32'h22222222);

    step(0, 8'h00, '0, 3'd0, 3'd0, 0);
    for (int i = 0; i < 255; i++) step(1, 8'(1 << (i % 8)), $urandom, 3'(i), 3'(i + 1), 0);
    chk("wcnt_255", W'(bus.WCNT), W'(8'hFF));
    step(1, 8'h02, $urandom, 3'd1, 3'd1, 1);
    chk("wcnt_wrap", W'(bus.WCNT), '0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      idx = 3'($urandom_range(0, 7));
      if (r < 6)       we = 8'(1 << idx);
      else if (r < 8)  we = 8'h00;
      else             we = 8'($urandom) | 8'(3 << ($urandom_range(0, 6)));
      a1 = ($urandom_range(0, 1) == 1) ? idx : 3'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 1) == 1) ? idx : 3'($urandom_range(0, 7));
      step(($urandom_range(0, 49) != 0), we, $urandom, a1, a2, ($urandom_range(0, 3) != 0));
    end

    step(1, 8'h80, 32'hCAFE_F00D, 3'd7, 3'd7, 1);
    step(1, 8'h81, 32'h0, 3'd7, 3'd0, 1);
    step(0, 8'h80, 32'h5555_AAAA, 3'd7, 3'd7, 1);
    chk("midrst_rvalid", W'(bus.RVALID), '0);
    chk("midrst_werr",   W'(bus.WERR),   '0);
    chk("midrst_wcnt",   W'(bus.WCNT),   '0);
    step(1, 8'h00, '0, 3'd7, 3'd7, 1);
    chk("midrst_r7", bus.RD1, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile8.md
REGFILE8 -- requirements
Module: regfile8

Interface
REQ-001 Parameter: WIDTH, default 32, data width of each register and of the read/write data ports.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RSTn  input  1  reset, synchronous, active-low.
REQ-004 WE  input  8  one-hot write strobes, driven directly by the upstream 3-to-8 decoder; bit i selects register i.
REQ-005 WD  input  WIDTH  write data.
REQ-006 RA1  input  3  read address, port 1.
REQ-007 RA2  input  3  read address, port 2.
REQ-008 RE  input  1  read request, both ports.
REQ-009 RD1  output  WIDTH  registered read data, port 1.
REQ-010 RD2  output  WIDTH  registered read data, port 2.
REQ-011 RVALID  output  1  RD1/RD2 hold data captured on the previous edge.
REQ-012 WERR  output  1  sticky flag: a multi-hot WE was presented.
REQ-013 WCNT  output  8  count of completed writes.

Function
REQ-014 Storage SHALL be eight registers of WIDTH bits, R0..R7.
REQ-015 WE with exactly one bit i set at an edge SHALL load WD into Ri; all other registers hold.
REQ-016 WE == 8'h00 SHALL write nothing (decoder disabled).
REQ-017 WE with two or more bits set SHALL write nothing, SHALL set WERR to 1, and SHALL leave WCNT unchanged.
REQ-018 WERR SHALL stay 1 until reset; later valid writes do not clear it.
REQ-019 WCNT SHALL increment by 1 on every edge with a valid one-hot write, wrapping 8'hFF -> 8'h00.
REQ-020 RE=1 at an edge SHALL load RD1 <= R[RA1] and RD2 <= R[RA2], and set RVALID to 1; read latency is 1 cycle.
REQ-021 RE=0 at an edge SHALL clear RVALID to 0; RD1/RD2 SHALL hold their last values.
REQ-022 RA1 == RA2 SHALL return identical data on both ports.
REQ-023 A write and a read of the same register on the same edge SHALL behave as defined by REQ-028/REQ-029. Writes and reads of different registers SHALL be independent.
REQ-024 Back-to-back RE cycles SHALL produce one new RD1/RD2 sample per cycle, with RVALID held at 1.

Reset
REQ-025 RSTn=0 at an edge SHALL clear R0..R7, RD1, RD2, WCNT to 0 and RVALID, WERR to 0.
REQ-026 RSTn=0 SHALL override any WE/RE on that edge; no write or read takes effect.
REQ-027 The first edge with RSTn=1 SHALL accept writes and reads normally.

Configuration
REQ-028 With macro REGFILE8_BYPASS_EN defined, a read of register i on the same edge as a valid write to register i SHALL return the new WD on RD1/RD2 (write-through forwarding).
REQ-029 Without REGFILE8_BYPASS_EN, the same case SHALL return the pre-write contents; the new value is visible from the following read onward.

Verification
REQ-030 Reset, then RE=1, RA1=3, RA2=5 -> next cycle RD1=0, RD2=0, RVALID=1, WCNT=0, WERR=0.
REQ-031 WE=8'h04, WD=32'hDEADBEEF; next cycle RE=1, RA1=2 -> RD1=32'hDEADBEEF, WCNT=1; registers other than R2 read 0.
REQ-032 WE=8'h0C, WD=32'h12345678 -> WERR=1, WCNT unchanged, R2/R3 unchanged; then WE=8'h01 valid write -> WERR stays 1.
REQ-033 R4=32'h11111111; same edge WE=8'h10, WD=32'h22222222, RE=1, RA1=4 -> RD1=32'h22222222 with REGFILE8_BYPASS_EN, 32'h11111111 without.
REQ-034 256 consecutive valid writes from WCNT=0 -> WCNT=8'h00 (wrapped); the 255th leaves 8'hFF.
REQ-035 Mid-stream RSTn=0 with WE=8'h80, RE=1 -> R7=0, RVALID=0, WERR=0, WCNT=0 after the edge.
